i2c_byte_ctrl: RTL and testbench
================================

Name: i2c_byte_ctrl

Overview:
- Byte-level I2C transfer engine that sits directly upstream of i2c_bit_gen.
- Accepts one byte command (write or read) and serialises it into 8 data-bit requests, MSB first, plus 1 ACK-bit request on the bit generator's req/ready handshake.
- On a write: returns the slave ACK. On a read: returns the assembled byte.
- START/STOP conditions are out of scope; the transaction layer above handles them.

Parameters:
- TIMEOUT_CYCLES, 65535, max i_clk cycles to wait for any single bit to complete; 0 disables the watchdog.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous reset, active-high
- i_cmd_valid  in  1  byte command present
- o_cmd_ready  out  1  block idle, can accept a command
- i_cmd_rd  in  1  0 = write byte, 1 = read byte
- i_wr_byte  in  8  data to transmit (write)
- i_ack_out  in  1  ACK bit master drives after a read (0 = ACK, 1 = NACK)
- o_done  out  1  one-cycle pulse: byte+ACK finished
- o_rd_byte  out  8  received byte, valid with o_done on read
- o_ack_in  out  1  sampled slave ACK bit on write (1 = NACK), valid with o_done
- o_timeout  out  1  one-cycle pulse with o_done when watchdog expired
- o_bit_req  out  1  request to i2c_bit_gen
- o_bit_we  out  1  1 = write bit, 0 = read bit
- o_bit_wr_bit  out  1  bit value to drive
- i_bit_ready  in  1  bit generator idle
- i_bit_rd_valid  in  1  read bit valid pulse
- i_bit_rd_bit  in  1  sampled SDA

Behaviour:
- Reset (async, active-high): state = IDLE.
  - All outputs 0 except o_cmd_ready = 1.
  - o_rd_byte = 8'h00; shift register, bit counter (3 b) and watchdog cleared.
- IDLE: o_cmd_ready = 1.
  - On i_cmd_valid && o_cmd_ready, latch i_cmd_rd, i_wr_byte and i_ack_out; bit_cnt = 7; go to BIT_REQ next cycle.
  - o_cmd_ready = 0 from that next cycle until the cycle after o_done.
- BIT_REQ: o_bit_req = 1.
  - Write: o_bit_we = 1, o_bit_wr_bit = shreg[7].
  - Read: o_bit_we = 0, o_bit_wr_bit = 1 (SDA released).
  - Hold all three stable until i_bit_ready is sampled low (accepted), then drop o_bit_req and go to BIT_WAIT.
  - If i_bit_ready is already low on entry, wait; do not count it as acceptance until it has been seen high with req asserted (request never fires into a busy bit gen).
- BIT_WAIT: wait for i_bit_ready to return high.
  - On read, shift i_bit_rd_bit into shreg LSB on the i_bit_rd_valid cycle. i_bit_rd_valid may coincide with the ready rise; both are handled the same cycle.
  - On completion: if bit_cnt == 0, go to ACK_REQ; else decrement bit_cnt, shift (write), and return to BIT_REQ.
- ACK_REQ / ACK_WAIT: same handshake as BIT_REQ/BIT_WAIT.
  - Write: read bit (o_bit_we = 0); the i_bit_rd_bit captured on i_bit_rd_valid goes to o_ack_in.
  - Read: write bit with o_bit_wr_bit = latched i_ack_out.
- DONE: one cycle.
  - o_done = 1.
  - Read: o_rd_byte = shreg. Write: o_rd_byte holds its previous value.
  - Return to IDLE.
- Latency per byte = 9 bit-gen transactions + 3 cycles of overhead (accept, BIT_REQ entry, DONE).
- Watchdog:
  - Counts in BIT_REQ/BIT_WAIT/ACK_REQ/ACK_WAIT; reloads on every completed bit.
  - On reaching TIMEOUT_CYCLES: drop o_bit_req, go to DONE with o_timeout = 1, o_ack_in = 1, o_rd_byte unchanged.
- i_cmd_valid while busy: ignored; the upstream holds it until o_cmd_ready.
- Mid-transfer reset: immediate return to reset values; o_bit_req deasserts asynchronously.

Decomposition:
- Shared package i2c_pkg holds:
  - typedef enum byte_state_t {IDLE, BIT_REQ, BIT_WAIT, ACK_REQ, ACK_WAIT, DONE}
  - localparams I2C_ACK = 1'b0, I2C_NACK = 1'b1, I2C_BITS_PER_BYTE = 8
- No sub-module needed; the watchdog is an inline counter.
- The bench instantiates this block driving i2c_bit_gen with pulled-up open-drain SDA/SCL and a bit-level slave model.

Test Plan:
- Write 8'hA5, slave ACKs (SDA low on 9th SCL high): SDA during SCL-high = 1,0,1,0,0,1,0,1; o_done pulse, o_ack_in = 0, o_timeout = 0.
- Write 8'h3C, no slave (SDA floats high): o_ack_in = 1 (NACK); o_cmd_ready returns high the cycle after o_done.
- Read with i_ack_out = 0, slave drives 8'h96: o_rd_byte = 8'h96 at o_done; master drives SDA low during the 9th SCL high.
- Read with i_ack_out = 1, slave drives 8'h01, slave stretches SCL low for 20 cycles on bit 3: o_rd_byte = 8'h01; master leaves SDA high on the ACK bit; no timeout.
- TIMEOUT_CYCLES = 100, slave holds SCL low permanently: o_done and o_timeout pulse together about 100 cycles after the stalled bit; o_bit_req = 0 afterwards; next command is accepted normally.
- Assert i_rst after the 4th bit of a write of 8'hFF: all outputs at reset values immediately, o_cmd_ready = 1; after release, a write of 8'h55 completes correctly.

Source files
------------

// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared types and constants for the byte-level I2C engine.
//   byte_state_t      : byte controller FSM states
//   I2C_ACK/I2C_NACK  : SDA level of the ninth (acknowledge) bit
//   I2C_BITS_PER_BYTE : data bits serialised per byte, MSB first
// -----------------------------------------------------------------------------
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        BIT_REQ  = 3'd1,
        BIT_WAIT = 3'd2,
        ACK_REQ  = 3'd3,
        ACK_WAIT = 3'd4,
        DONE     = 3'd5
    } byte_state_t;

    localparam logic I2C_ACK           = 1'b0;
    localparam logic I2C_NACK          = 1'b1;
    localparam int   I2C_BITS_PER_BYTE = 8;

endpackage

// File: rtl/i2c_byte_ctrl.sv
// -----------------------------------------------------------------------------
// i2c_byte_ctrl
// Byte-level I2C transfer engine feeding i2c_bit_gen. One command moves one
// byte: eight data-bit requests MSB first, then one acknowledge-bit request,
// all over the bit generator's req/ready handshake.
//
// Parameters
//   TIMEOUT_CYCLES : max clock cycles any single bit may take; 0 = no watchdog
// Ports
//   i_clk, i_rst                 : clock, asynchronous active-high reset
//   i_cmd_valid / o_cmd_ready    : command handshake (ready only when idle)
//   i_cmd_rd                     : 0 = write byte, 1 = read byte
//   i_wr_byte                    : byte to transmit on a write
//   i_ack_out                    : ACK level the master drives after a read
//   o_done                       : one-cycle pulse when byte + ACK finished
//   o_rd_byte                    : received byte, updated with o_done on read
//   o_ack_in                     : slave ACK sampled on write (1 = NACK)
//   o_timeout                    : pulses with o_done when the watchdog fired
//   o_bit_req/o_bit_we/o_bit_wr_bit : request, direction and value to bit gen
//   i_bit_ready                  : bit generator idle
//   i_bit_rd_valid/i_bit_rd_bit  : sampled SDA from the bit generator
// -----------------------------------------------------------------------------
module i2c_byte_ctrl
    import i2c_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic       i_cmd_rd,
    input  logic [7:0] i_wr_byte,
    input  logic       i_ack_out,
    output logic       o_done,
    output logic [7:0] o_rd_byte,
    output logic       o_ack_in,
    output logic       o_timeout,
    output logic       o_bit_req,
    output logic       o_bit_we,
    output logic       o_bit_wr_bit,
    input  logic       i_bit_ready,
    input  logic       i_bit_rd_valid,
    input  logic       i_bit_rd_bit
);

    // The watchdog counts 0 .. TIMEOUT_CYCLES-1 and fires on the last value.
    localparam int unsigned     WD_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    byte_state_t     state;
    logic [7:0]      shreg;
    logic [2:0]      bit_cnt;
    logic            is_rd;
    logic            ack_out_q;
    logic            seen_ready;  // bit gen was idle while our request was up
    logic            ack_cap;     // slave ACK captured during ACK_WAIT
    logic [WD_W-1:0] wd_cnt;

    logic            in_xfer;
    logic            wd_expired;
    logic [7:0]      shreg_rd;    // shreg with this cycle's read bit folded in

    assign in_xfer    = (state == BIT_REQ)  || (state == BIT_WAIT) ||
                        (state == ACK_REQ)  || (state == ACK_WAIT);
    assign wd_expired = (TIMEOUT_CYCLES != 0) && in_xfer && (wd_cnt == WD_LAST);
    assign shreg_rd   = (is_rd && i_bit_rd_valid) ? {shreg[6:0], i_bit_rd_bit} : shreg;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            shreg        <= 8'h00;
            bit_cnt      <= 3'd0;
            is_rd        <= 1'b0;
            ack_out_q    <= 1'b0;
            seen_ready   <= 1'b0;
            ack_cap      <= 1'b0;
            wd_cnt       <= '0;
            o_cmd_ready  <= 1'b1;
            o_done       <= 1'b0;
            o_rd_byte    <= 8'h00;
            o_ack_in     <= 1'b0;
            o_timeout    <= 1'b0;
            o_bit_req    <= 1'b0;
            o_bit_we     <= 1'b0;
            o_bit_wr_bit <= 1'b0;
        end else begin
            // NOTE: defaults first, later non-blocking assignments in the same
            // block override them, so pulses need no explicit clear per state.
            o_done    <= 1'b0;
            o_timeout <= 1'b0;
            if (in_xfer) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end

            if (wd_expired) begin
                // Abandon the byte; o_rd_byte deliberately left untouched.
                state      <= DONE;
                o_bit_req  <= 1'b0;
                seen_ready <= 1'b0;
                o_done     <= 1'b1;
                o_timeout  <= 1'b1;
                o_ack_in   <= I2C_NACK;
            end else begin
                case (state)
                    IDLE: begin
                        // o_cmd_ready is always high in IDLE.
                        if (i_cmd_valid) begin
                            is_rd        <= i_cmd_rd;
                            ack_out_q    <= i_ack_out;
                            shreg        <= i_wr_byte;
                            bit_cnt      <= 3'(I2C_BITS_PER_BYTE - 1);
                            wd_cnt       <= '0;
                            seen_ready   <= 1'b0;
                            o_cmd_ready  <= 1'b0;
                            o_bit_req    <= 1'b1;
                            o_bit_we     <= ~i_cmd_rd;
                            o_bit_wr_bit <= i_cmd_rd ? 1'b1 : i_wr_byte[7];
                            state        <= BIT_REQ;
                        end
                    end

                    BIT_REQ, ACK_REQ: begin
                        // Accepted only once ready was seen high under our
                        // request and has since dropped; a low ready on entry
                        // belongs to a bit gen that is still busy.
                        if (i_bit_ready) begin
                            seen_ready <= 1'b1;
                        end else if (seen_ready) begin
                            seen_ready <= 1'b0;
                            o_bit_req  <= 1'b0;
                            state      <= (state == BIT_REQ) ? BIT_WAIT : ACK_WAIT;
                        end
                    end

                    BIT_WAIT: begin
                        shreg <= shreg_rd;
                        if (i_bit_ready) begin
                            wd_cnt    <= '0;
                            o_bit_req <= 1'b1;
                            if (bit_cnt == 3'd0) begin
                                ack_cap      <= I2C_NACK;
                                o_bit_we     <= is_rd;
                                o_bit_wr_bit <= is_rd ? ack_out_q : 1'b1;
                                state        <= ACK_REQ;
                            end else begin
                                bit_cnt <= bit_cnt - 3'd1;
                                if (!is_rd) begin
                                    shreg <= {shreg[6:0], 1'b0};
                                end
                                o_bit_wr_bit <= is_rd ? 1'b1 : shreg[6];
                                state        <= BIT_REQ;
                            end
                        end
                    end

                    ACK_WAIT: begin
                        if (!is_rd && i_bit_rd_valid) begin
                            ack_cap <= i_bit_rd_bit;
                        end
                        if (i_bit_ready) begin
                            wd_cnt <= '0;
                            o_done <= 1'b1;
                            state  <= DONE;
                            if (is_rd) begin
                                o_rd_byte <= shreg;
                                o_ack_in  <= I2C_ACK;
                            end else begin
                                o_ack_in  <= i_bit_rd_valid ? i_bit_rd_bit : ack_cap;
                            end
                        end
                    end

                    DONE: begin
                        o_cmd_ready <= 1'b1;
                        state       <= IDLE;
                    end

                    default: begin
                        o_cmd_ready <= 1'b1;
                        o_bit_req   <= 1'b0;
                        state       <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_byte_ctrl.sv
// -----------------------------------------------------------------------------
// tb_i2c_byte_ctrl
// Directed bench for i2c_byte_ctrl. A behavioural bit-generator model answers
// the req/ready handshake, logs every bit request (direction and driven SDA
// level) and returns slave SDA bits on reads, with optional SCL stretch or
// permanent stall on a chosen bit. Expected values are hand-derived.
// -----------------------------------------------------------------------------
module tb_i2c_byte_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_rd, ack_out;
    logic [7:0] wr_byte, rd_byte;
    logic       done, ack_in, timeout;
    logic       bit_req, bit_we, bit_wr_bit;
    logic       bit_ready, bit_rd_valid, bit_rd_bit;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Bit generator model state and log
    logic       log_we  [0:255];
    logic       log_bit [0:255];
    int         acc_cyc [0:255];
    int         bg_cnt    = 0;
    int         byte_base = 0;
    logic [7:0] slave_byte = 8'h00;
    logic       slave_ack  = 1'b0;
    int         stretch_idx = -1;
    int         stretch_len = 0;
    int         stall_idx   = -1;
    logic       stall_on    = 1'b0;

    i2c_byte_ctrl #(.TIMEOUT_CYCLES(100)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_cmd_valid    (cmd_valid),
        .o_cmd_ready    (cmd_ready),
        .i_cmd_rd       (cmd_rd),
        .i_wr_byte      (wr_byte),
        .i_ack_out      (ack_out),
        .o_done         (done),
        .o_rd_byte      (rd_byte),
        .o_ack_in       (ack_in),
        .o_timeout      (timeout),
        .o_bit_req      (bit_req),
        .o_bit_we       (bit_we),
        .o_bit_wr_bit   (bit_wr_bit),
        .i_bit_ready    (bit_ready),
        .i_bit_rd_valid (bit_rd_valid),
        .i_bit_rd_bit   (bit_rd_bit)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // Bit generator: accepts on req && ready at an edge, stays busy a few
    // cycles, then raises ready. Read bits come with rd_valid either on the
    // ready rise (even bit index) or one cycle earlier (odd bit index).
    initial begin : bit_gen_model
        int   k, n;
        logic acc, we_s, rbit, aborted;
        bit_ready    = 1'b1;
        bit_rd_valid = 1'b0;
        bit_rd_bit   = 1'b0;
        forever begin
            @(posedge clk);
            acc = !rst && bit_req && bit_ready;
            if (acc) begin
                k                = bg_cnt - byte_base;
                we_s             = bit_we;
                log_we[bg_cnt]   = bit_we;
                log_bit[bg_cnt]  = bit_wr_bit;
                acc_cyc[bg_cnt]  = cyc;
                bg_cnt++;
                rbit = (k < 8) ? slave_byte[7-k] : slave_ack;
            end
            #1;
            bit_rd_valid = 1'b0;
            if (acc) begin
                bit_ready = 1'b0;
                aborted   = 1'b0;
                n = 2 + ((k == stretch_idx) ? stretch_len : 0);
                for (int c = 0; c < n || (k == stall_idx && stall_on); c++) begin
                    @(posedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                end
                #1;
                if (!aborted && !we_s && k[0]) begin
                    bit_rd_valid = 1'b1;
                    bit_rd_bit   = rbit;
                    @(posedge clk);
                    #1;
                    bit_rd_valid = 1'b0;
                end
                bit_ready = 1'b1;
                if (!aborted && !we_s && !k[0]) begin
                    bit_rd_valid = 1'b1;
                    bit_rd_bit   = rbit;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] logged_bits(input int base);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[7-i] = log_bit[base+i];
        return b;
    endfunction

    function automatic logic [7:0] logged_we(input int base);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[7-i] = log_we[base+i];
        return b;
    endfunction

    // Presents a command and returns #1 after the edge that accepted it.
    task automatic issue_cmd(input logic rd, input logic [7:0] wb, input logic ack);
        logic seen;
        seen = 1'b0;
        @(posedge clk);
        #1;
        byte_base = bg_cnt;
        cmd_valid = 1'b1;
        cmd_rd    = rd;
        wr_byte   = wb;
        ack_out   = ack;
        for (int i = 0; i < 100; i++) begin
            if (cmd_ready) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("cmd_accept", seen, 1'b1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Waits for o_done, captures the results, checks the ready turnaround.
    task automatic wait_done(output logic [7:0] rdb, output logic acki,
                             output logic to, output int dcyc);
        logic got;
        got  = 1'b0;
        rdb  = 8'hxx;
        acki = 1'bx;
        to   = 1'bx;
        dcyc = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                got  = 1'b1;
                rdb  = rd_byte;
                acki = ack_in;
                to   = timeout;
                dcyc = cyc;
                break;
            end
        end
        check("done_seen", got, 1'b1);
        if (got) begin
            check("ready_low_at_done", cmd_ready, 1'b0);
            @(posedge clk);
            #1;
            check("ready_after_done", cmd_ready, 1'b1);
            check("done_one_cycle", done, 1'b0);
        end
    endtask

    initial begin : stimulus
        logic [7:0] rdb;
        logic       acki, to;
        int         dcyc, d;
        logic       reached;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_rd    = 1'b0;
        wr_byte   = 8'h00;
        ack_out   = 1'b0;

        // Reset state
        #12;
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_outputs", {done, ack_in, timeout, bit_req, bit_we, bit_wr_bit}, 6'b0);
        check("rst_rd_byte", rd_byte, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // 1: write A5, slave ACKs
        slave_ack = 1'b0;
        issue_cmd(1'b0, 8'hA5, 1'b0);
        wait_done(rdb, acki, to, dcyc);
        check("w_a5_sda_bits", logged_bits(byte_base), 8'hA5);
        check("w_a5_data_we", logged_we(byte_base), 8'hFF);
        check("w_a5_ack_is_read", log_we[byte_base+8], 1'b0);
        check("w_a5_ack_in", acki, 1'b0);
        check("w_a5_timeout", to, 1'b0);
        check("w_a5_rd_byte_held", rdb, 8'h00);

        // 2: write 3C, no slave -> NACK
        slave_ack = 1'b1;
        issue_cmd(1'b0, 8'h3C, 1'b0);
        wait_done(rdb, acki, to, dcyc);
        check("w_3c_sda_bits", logged_bits(byte_base), 8'h3C);
        check("w_3c_ack_in", acki, 1'b1);
        check("w_3c_timeout", to, 1'b0);

        // 3: read 96, master ACKs
        slave_byte = 8'h96;
        issue_cmd(1'b1, 8'h00, 1'b0);
        wait_done(rdb, acki, to, dcyc);
        check("r_96_rd_byte", rdb, 8'h96);
        check("r_96_data_we", logged_we(byte_base), 8'h00);
        check("r_96_sda_released", logged_bits(byte_base), 8'hFF);
        check("r_96_ack_is_write", log_we[byte_base+8], 1'b1);
        check("r_96_ack_driven_low", log_bit[byte_base+8], 1'b0);
        check("r_96_timeout", to, 1'b0);

        // 4: read 01, master NACKs, SCL stretched 20 cycles on bit 3
        slave_byte  = 8'h01;
        stretch_idx = 3;
        stretch_len = 20;
        issue_cmd(1'b1, 8'h00, 1'b1);
        wait_done(rdb, acki, to, dcyc);
        stretch_idx = -1;
        check("r_01_rd_byte", rdb, 8'h01);
        check("r_01_ack_is_write", log_we[byte_base+8], 1'b1);
        check("r_01_ack_released", log_bit[byte_base+8], 1'b1);
        check("r_01_timeout", to, 1'b0);

        // 5: write C3 with bit 2 stalled forever -> watchdog
        slave_ack = 1'b0;
        stall_idx = 2;
        stall_on  = 1'b1;
        issue_cmd(1'b0, 8'hC3, 1'b0);
        wait_done(rdb, acki, to, dcyc);
        d = dcyc - acc_cyc[byte_base+2];
        check("to_flag", to, 1'b1);
        check("to_ack_in", acki, 1'b1);
        check("to_rd_byte_held", rdb, 8'h01);
        check("to_latency_90_110", (d >= 90 && d <= 110), 1'b1);
        check("to_req_dropped", bit_req, 1'b0);
        stall_on  = 1'b0;
        stall_idx = -1;
        repeat (10) @(posedge clk);
        #1;
        check("to_req_stays_low", bit_req, 1'b0);

        // 6: next command after timeout works normally
        issue_cmd(1'b0, 8'h5A, 1'b0);
        wait_done(rdb, acki, to, dcyc);
        check("post_to_sda_bits", logged_bits(byte_base), 8'h5A);
        check("post_to_ack_in", acki, 1'b0);
        check("post_to_timeout", to, 1'b0);

        // 7: reset in the middle of a write of FF (after 4 bits)
        issue_cmd(1'b0, 8'hFF, 1'b0);
        reached = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bg_cnt - byte_base >= 5) begin
                reached = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("mid_fifth_bit_reached", reached, 1'b1);
        check("mid_req_before_rst", bit_req, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_cmd_ready", cmd_ready, 1'b1);
        check("mid_rst_outputs", {done, ack_in, timeout, bit_req, bit_we, bit_wr_bit}, 6'b0);
        check("mid_rst_rd_byte", rd_byte, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);

        issue_cmd(1'b0, 8'h55, 1'b0);
        wait_done(rdb, acki, to, dcyc);
        check("post_rst_sda_bits", logged_bits(byte_base), 8'h55);
        check("post_rst_ack_in", acki, 1'b0);
        check("post_rst_timeout", to, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
